mod6_count_monitor: RTL and testbench

- Reader-side companion to the mod-6 up/down T-flip-flop counter.
- Samples the counter's 3-bit state output together with the same enable/reverse controls the counter receives.
- Locks onto the count and checks every transition against the legal mod-6 sequence: up 0→1→…→5→0, down 5→4→…→0→5.
- Reports wrap events, sequence errors and a saturating error tally; sits beside the counter in the same clk domain for self-check and status.

---
 rtl/mod6_mon_pkg.sv | 19 +
 rtl/mod6_count_monitor_if.sv | 33 +++
 rtl/mod6_next.sv | 19 +
 rtl/mod6_count_monitor.sv | 114 +++++++++++
 tb/tb_mod6_count_monitor.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mod6_mon_pkg.sv
// Shared types and helpers for the mod-6 counter monitor.
// The optional hold check is enabled with the macro MOD6_MON_HOLD_CHECK_EN.
package mod6_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } mon_state_t;

  localparam int         MOD_N   = 6;
  localparam logic [2:0] MAX_VAL = 3'd5;

  // Only the six codes 0..5 are reachable by a healthy counter.
  function automatic logic is_legal(input logic [2:0] q);
    return (q <= MAX_VAL);
  endfunction

endpackage

// File: rtl/mod6_count_monitor_if.sv
// Bundle of counter-side observations and monitor status for mod6_count_monitor.
// All inputs are sampled on every rising clk edge; there is no backpressure, so no valid/ready pair exists.
interface mod6_count_monitor_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
);
  import mod6_mon_pkg::*;

  logic              enable;
  logic              reverse;
  logic              load_evt;
  logic              clear;
  logic [2:0]        q;

  logic              locked;
  logic              fault;
  logic              err;
  logic [WRAP_W-1:0] up_wraps;
  logic [WRAP_W-1:0] dn_wraps;
  logic [ERR_W-1:0]  err_count;
  mon_state_t        state;

  modport master (
    output enable, reverse, load_evt, clear, q,
    input  locked, fault, err, up_wraps, dn_wraps, err_count, state
  );

  modport slave (
    input  enable, reverse, load_evt, clear, q,
    output locked, fault, err, up_wraps, dn_wraps, err_count, state
  );

endinterface

// File: rtl/mod6_next.sv
// Combinational mod-6 successor: up 5->0 else +1, down 0->5 else -1.
module mod6_next
  import mod6_mon_pkg::*;
(
  input  logic [2:0] val,
  input  logic       rev,
  output logic [2:0] nxt
);

  always_comb begin
    nxt = 3'd0;
    if (rev) begin
      nxt = (val == 3'd0) ? MAX_VAL : (val - 3'd1);
    end else begin
      nxt = (val >= MAX_VAL) ? 3'd0 : (val + 3'd1);
    end
  end

endmodule

// File: rtl/mod6_count_monitor.sv
// Locks onto a mod-6 up/down counter and checks each transition; counts wraps and errors.
// Optional: define MOD6_MON_HOLD_CHECK_EN to flag any q change while the counter was disabled.
module mod6_count_monitor
  import mod6_mon_pkg::*;
#(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mod6_count_monitor_if.slave  bus
);

  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};

  mon_state_t        state, next_state;
  logic [2:0]        prev_q;
  logic              prev_en;
  logic              prev_rev;
  logic              err_r;
  logic [WRAP_W-1:0] up_r, dn_r;
  logic [ERR_W-1:0]  errc_r;

  logic [2:0] nxt_q;
  logic [2:0] exp_q;
  logic       q_ok;
  logic       violation;
  logic       up_hit;
  logic       dn_hit;

  mod6_next u_next (
    .val (prev_q),
    .rev (prev_rev),
    .nxt (nxt_q)
  );

  assign exp_q = prev_en ? nxt_q : prev_q;

  always_comb begin
    next_state = state;
    violation  = 1'b0;
    up_hit     = 1'b0;
    dn_hit     = 1'b0;
    q_ok       = is_legal(bus.q) && (bus.q == exp_q);
`ifndef MOD6_MON_HOLD_CHECK_EN
    // A disabled counter that moves anyway is simply re-tracked from its new value.
    if (!prev_en && is_legal(bus.q)) q_ok = 1'b1;
`endif

    case (state)
      UNLOCKED: begin
        if (is_legal(bus.q)) next_state = LOCKED;
      end
      LOCKED: begin
        if (!q_ok) begin
          violation  = 1'b1;
          next_state = FAULT;
        end else begin
          up_hit = prev_en && !prev_rev && (prev_q == MAX_VAL) && (bus.q == 3'd0);
          dn_hit = prev_en &&  prev_rev && (prev_q == 3'd0) && (bus.q == MAX_VAL);
        end
      end
      FAULT:   next_state = FAULT;
      default: next_state = UNLOCKED;
    endcase

    // clear outranks load_evt, which outranks the check; both suppress err and wraps.
    if (bus.clear || bus.load_evt) begin
      next_state = UNLOCKED;
      violation  = 1'b0;
      up_hit     = 1'b0;
      dn_hit     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNLOCKED;
      prev_q   <= 3'd0;
      prev_en  <= 1'b0;
      prev_rev <= 1'b0;
      err_r    <= 1'b0;
      up_r     <= '0;
      dn_r     <= '0;
      errc_r   <= '0;
    end else begin
      state    <= next_state;
      prev_q   <= bus.q;
      prev_en  <= bus.enable;
      prev_rev <= bus.reverse;
      err_r    <= violation;
      if (bus.clear) begin
        up_r   <= '0;
        dn_r   <= '0;
        errc_r <= '0;
      end else begin
        if (up_hit) up_r <= up_r + WRAP_ONE;
        if (dn_hit) dn_r <= dn_r + WRAP_ONE;
        if (violation && (errc_r != ERR_MAX)) errc_r <= errc_r + ERR_ONE;
      end
    end
  end

  assign bus.locked    = (state == LOCKED);
  assign bus.fault     = (state == FAULT);
  assign bus.err       = err_r;
  assign bus.up_wraps  = up_r;
  assign bus.dn_wraps  = dn_r;
  assign bus.err_count = errc_r;
  assign bus.state     = state;

endmodule

// File: tb/tb_mod6_count_monitor.sv
// Directed bench for mod6_count_monitor: vector table plus saturation and async-reset sequences.
module tb_mod6_count_monitor;
  import mod6_mon_pkg::*;

`ifdef MOD6_MON_HOLD_CHECK_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  mod6_count_monitor_if #(.WRAP_W(8), .ERR_W(4)) bus ();

  mod6_count_monitor #(.WRAP_W(8), .ERR_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rev;
    logic       ld;
    logic       clr;
    logic [2:0] q;
    logic       locked;
    logic       fault;
    logic       err;
    int         up;
    int         dn;
    int         errc;
  } vec_t;

  vec_t vecs [30];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rev, input logic ld, input logic clr, input logic [2:0] qv);
    bus.enable   = en;
    bus.reverse  = rev;
    bus.load_evt = ld;
    bus.clear    = clr;
    bus.q        = qv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic l, input logic f, input logic e,
                           input int up, input int dn, input int ec);
    check({tag, ".locked"}, idx, 32'(bus.locked), 32'(l));
    check({tag, ".fault"},  idx, 32'(bus.fault),  32'(f));
    check({tag, ".err"},    idx, 32'(bus.err),    32'(e));
    check({tag, ".up"},     idx, 32'(bus.up_wraps),  32'(up));
    check({tag, ".dn"},     idx, 32'(bus.dn_wraps),  32'(dn));
    check({tag, ".errc"},   idx, 32'(bus.err_count), 32'(ec));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //          en rev ld clr q     lk flt err up dn errc
    vecs[0]  = '{1, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 3'd3, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 3'd5, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, 3'd0, 1, 0, 0, 1, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 3'd1, 1, 0, 0, 1, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 3'd2, 1, 0, 0, 1, 0, 0};
    vecs[9]  = '{1, 1, 0, 0, 3'd1, 1, 0, 0, 1, 0, 0};
    vecs[10] = '{1, 1, 0, 0, 3'd0, 1, 0, 0, 1, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 3'd5, 1, 0, 0, 1, 1, 0};
    vecs[12] = '{1, 1, 0, 0, 3'd4, 1, 0, 0, 1, 1, 0};
    vecs[13] = '{1, 0, 0, 0, 3'd3, 1, 0, 0, 1, 1, 0};
    vecs[14] = '{1, 0, 0, 0, 3'd5, 0, 1, 1, 1, 1, 1};
    vecs[15] = '{1, 0, 0, 0, 3'd0, 0, 1, 0, 1, 1, 1};
    vecs[16] = '{1, 0, 0, 0, 3'd2, 0, 1, 0, 1, 1, 1};
    vecs[17] = '{0, 0, 1, 0, 3'd4, 0, 0, 0, 1, 1, 1};
    vecs[18] = '{0, 0, 0, 0, 3'd4, 1, 0, 0, 1, 1, 1};
    vecs[19] = '{0, 0, 0, 0, 3'd4, 1, 0, 0, 1, 1, 1};
    vecs[20] = '{0, 0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 0, 3'd6, 0, 1, 1, 0, 0, 1};
    vecs[23] = '{0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 1};
    vecs[24] = '{0, 0, 0, 0, 3'd1, 1, 0, 0, 0, 0, 1};
    vecs[25] = '{0, 0, 0, 0, 3'd3, H == 0, H == 1, H == 1, 0, 0, 1 + H};
    vecs[26] = '{1, 0, 0, 0, 3'd3, H == 0, H == 1, 0, 0, 0, 1 + H};
    vecs[27] = '{1, 0, 0, 0, 3'd4, H == 0, H == 1, 0, 0, 0, 1 + H};
    vecs[28] = '{1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 1 + H};
    vecs[29] = '{1, 0, 1, 1, 3'd2, 0, 0, 0, 0, 0, 0};

    reset_n      = 1'b0;
    bus.enable   = 1'b0;
    bus.reverse  = 1'b0;
    bus.load_evt = 1'b0;
    bus.clear    = 1'b0;
    bus.q        = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].en, vecs[i].rev, vecs[i].ld, vecs[i].clr, vecs[i].q);
      check_all("vec", i, vecs[i].locked, vecs[i].fault, vecs[i].err, vecs[i].up, vecs[i].dn, vecs[i].errc);
    end

    // sixteen injected faults: err_count saturates at 15, err is a single-cycle pulse
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 3'd0);
      drive(0, 0, 0, 0, 3'd0);
      check("sat.locked", i, 32'(bus.locked), 32'd1);
      drive(0, 0, 0, 0, 3'd7);
      check("sat.err", i, 32'(bus.err), 32'd1);
      check("sat.errc", i, 32'(bus.err_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      drive(0, 0, 0, 0, 3'd0);
      check("sat.err_pulse", i, 32'(bus.err), 32'd0);
      check("sat.fault", i, 32'(bus.fault), 32'd1);
    end

    // asynchronous reset between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 3'd2);
    check("post_rst.locked", 0, 32'(bus.locked), 32'd1);
    drive(1, 0, 0, 0, 3'd3);
    check("post_rst.err", 0, 32'(bus.err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
